fwd_sel_gen: RTL

//  Operand-forwarding control for the 3-input operand select muxes (one per operand) in front of the ALU.

---
 rtl/fwd_sel_gen_if.sv | 35 +++
 rtl/fwd_sel_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/fwd_sel_gen_if.sv
// ID-stage request and EX-stage forwarding-control bundle for fwd_sel_gen.
// FWD_STATS_EN adds the stall_cnt / fwd_cnt statistics outputs.
interface fwd_sel_gen_if #(parameter int ADDRW = 5);
    logic             id_valid;
    logic [ADDRW-1:0] id_rs1;
    logic [ADDRW-1:0] id_rs2;
    logic [ADDRW-1:0] id_rd;
    logic             id_wen;
    logic             id_isload;
    logic             flush;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             ex_valid;
    logic             stall;
`ifdef FWD_STATS_EN
    logic [15:0]      stall_cnt;
    logic [15:0]      fwd_cnt;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_wen, id_isload, flush,
        input  sel_a, sel_b, ex_valid, stall
`ifdef FWD_STATS_EN
        , input stall_cnt, fwd_cnt
`endif
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_wen, id_isload, flush,
        output sel_a, sel_b, ex_valid, stall
`ifdef FWD_STATS_EN
        , output stall_cnt, fwd_cnt
`endif
    );
endinterface

// File: rtl/fwd_sel_gen.sv
// Operand-forwarding select generator with load-use stall detection for a 5-stage pipe.
// Define FWD_STATS_EN to add saturating stall_cnt / fwd_cnt statistics counters.
module fwd_sel_gen #(
    parameter int ADDRW = 5
) (
    input  logic          clk,
    input  logic          rst,
    fwd_sel_gen_if.slave  bus
);
    logic             ex_valid_q, ex_valid_d;
    logic [ADDRW-1:0] ex_rd_q, ex_rd_d;
    logic             ex_wen_q, ex_wen_d;
    logic             ex_isload_q, ex_isload_d;
    logic             mem_valid_q, mem_valid_d;
    logic [ADDRW-1:0] mem_rd_q, mem_rd_d;
    logic             mem_wen_q, mem_wen_d;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;

    logic [2*ADDRW-1:0] src;
    logic [3:0]         sel_raw;
    logic [1:0]         ld_hit;
    logic               stall_c;
    logic               load_id;

    assign src = {bus.id_rs2, bus.id_rs1};

    // Per-operand producer match; the EX producer is younger and takes priority.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [ADDRW-1:0] rs;
            logic             ex_hit;
            logic             mem_hit;
            assign rs      = src[gi*ADDRW +: ADDRW];
            assign ex_hit  = ex_valid_q && ex_wen_q && (ex_rd_q == rs);
            assign mem_hit = mem_valid_q && mem_wen_q && (mem_rd_q == rs);
            assign sel_raw[2*gi +: 2] = (rs == '0) ? 2'b00 :
                                        ex_hit     ? 2'b01 :
                                        mem_hit    ? 2'b10 : 2'b00;
            assign ld_hit[gi] = ex_hit && ex_isload_q;
        end
    endgenerate

    // A flushed ID instruction is dead, so it can never request a stall.
    assign stall_c = bus.id_valid && !bus.flush && ex_valid_q && ex_wen_q &&
                     ex_isload_q && (ex_rd_q != '0) && (|ld_hit);
    assign load_id = bus.id_valid && !bus.flush && !stall_c;

    always_comb begin
        ex_valid_d  = load_id;
        ex_rd_d     = load_id ? bus.id_rd : '0;
        ex_wen_d    = load_id && bus.id_wen;
        ex_isload_d = load_id && bus.id_isload;
        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_wen_d   = ex_wen_q;
        sel_a_d     = load_id ? sel_raw[1:0] : 2'b00;
        sel_b_d     = load_id ? sel_raw[3:2] : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wen_q    <= 1'b0;
            ex_isload_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wen_q   <= 1'b0;
            sel_a_q     <= 2'b00;
            sel_b_q     <= 2'b00;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wen_q    <= ex_wen_d;
            ex_isload_q <= ex_isload_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wen_q   <= mem_wen_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
        end
    end

    assign bus.sel_a    = sel_a_q;
    assign bus.sel_b    = sel_b_q;
    assign bus.ex_valid = ex_valid_q;
    assign bus.stall    = stall_c;

`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;

    // fwd_cnt counts forwarded instructions, not forwarded operands.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_c && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (((sel_a_d != 2'b00) || (sel_b_d != 2'b00)) && (fwd_cnt_q != 16'hFFFF))
            fwd_cnt_d = fwd_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            fwd_cnt_q   <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif
endmodule
